// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding instruction fetch with next-pc selection for
//             jumps, jr and branches. Optional alignment fault checking is
//             enabled with the FETCH_ALIGN_CHECK_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  jmp,
    input  logic        branch,
    input  logic        branch_cond,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_DEC = 2'd1,
        S_FAULT    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_target;
    logic        r_run;

    assign pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target = pc_plus4;
        if (jmp == 2'b01 || jmp == 2'b10) begin
            w_target = {pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (jmp == 2'b11) begin
            w_target = jr_target;
        end else if (branch && branch_cond) begin
            w_target = pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        case (r_state)
            S_REQ: begin
                // r_run masks the first cycle after reset so a late ack from an
                // abandoned request cannot be mistaken for a new fetch.
                if (r_run && imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_WAIT_DEC;
                end
            end
            S_WAIT_DEC: begin
                if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    w_pc_nxt    = w_target;
                    w_state_nxt = (w_target[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
                    w_pc_nxt    = w_target & ~32'h0000_0003;
                    w_state_nxt = S_REQ;
`endif
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_run   <= 1'b1;
        end
    end

    assign imem_req    = (r_state == S_REQ) && r_run;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_WAIT_DEC);
    assign pc          = r_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fault = (r_state == S_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Table-driven directed bench for fetch_unit (default build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  jmp;
    logic        branch;
    logic        branch_cond;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;

    int n_chk = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jmp         (jmp),
        .branch      (branch),
        .branch_cond (branch_cond),
        .jr_target   (jr_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  jmp;
        logic        br;
        logic        cond;
        logic [31:0] jrt;
        int          ack_dly;
        int          rdy_dly;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic benign();
        jmp         = 2'b00;
        branch      = 1'b0;
        branch_cond = 1'b0;
        jr_target   = 32'h0;
    endtask

    task automatic garbage();
        jmp         = 2'b11;
        branch      = 1'b1;
        branch_cond = 1'b1;
        jr_target   = 32'hDEAD_BEE0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("req_timeout", {31'h0, imem_req}, 32'h1);
    endtask

    task automatic do_fetch(input vec_t v);
        wait_req();
        chk("req_addr", imem_addr, v.addr);
        for (int i = 0; i < v.ack_dly; i++) begin
            imem_ack    = 1'b0;
            instr_ready = 1'b1;
            garbage();
            tick();
            chk("stall_req", {31'h0, imem_req}, 32'h1);
            chk("stall_addr", imem_addr, v.addr);
            chk("stall_valid", {31'h0, instr_valid}, 32'h0);
        end
        instr_ready = 1'b0;
        benign();
        imem_ack    = 1'b1;
        imem_rdata  = v.rdata;
        tick();
        chk("fetch_valid", {31'h0, instr_valid}, 32'h1);
        chk("fetch_instr", instr, v.rdata);
        chk("fetch_pc", pc, v.addr);
        chk("fetch_pc4", pc_plus4, v.addr + 32'd4);
        chk("fetch_req_low", {31'h0, imem_req}, 32'h0);
        chk("fetch_fault", {31'h0, fault}, 32'h0);
        for (int i = 0; i < v.rdy_dly; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
            garbage();
            tick();
            chk("dstall_valid", {31'h0, instr_valid}, 32'h1);
            chk("dstall_instr", instr, v.rdata);
            chk("dstall_pc", pc, v.addr);
            chk("dstall_req", {31'h0, imem_req}, 32'h0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jmp         = v.jmp;
        branch      = v.br;
        branch_cond = v.cond;
        jr_target   = v.jrt;
        tick();
        instr_ready = 1'b0;
        benign();
        chk("hs_valid_low", {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          rdata         jmp    br    cond  jrt           ack rdy
        tbl[0]  = '{32'h0000_0000, 32'h2000_0000, 2'b00, 1'b0, 1'b0, 32'h0,        1, 0};
        tbl[1]  = '{32'h0000_0004, 32'h2000_0001, 2'b00, 1'b0, 1'b0, 32'h0,        1, 0};
        tbl[2]  = '{32'h0000_0008, 32'h0800_0004, 2'b10, 1'b0, 1'b0, 32'h0,        1, 0};
        tbl[3]  = '{32'h0000_0010, 32'h2000_0003, 2'b00, 1'b0, 1'b0, 32'h0,        3, 4};
        tbl[4]  = '{32'h0000_0014, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'h1000_0040, 0, 0};
        tbl[5]  = '{32'h1000_0040, 32'h0800_0010, 2'b10, 1'b0, 1'b0, 32'h0,        0, 1};
        tbl[6]  = '{32'h1000_0040, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'h0000_0100, 0, 0};
        tbl[7]  = '{32'h0000_0100, 32'h14A5_FFFE, 2'b00, 1'b1, 1'b1, 32'h0,        0, 0};
        tbl[8]  = '{32'h0000_00FC, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'h0000_0100, 0, 0};
        tbl[9]  = '{32'h0000_0100, 32'h14A5_FFFE, 2'b00, 1'b1, 1'b0, 32'h0,        0, 0};
        tbl[10] = '{32'h0000_0104, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'h0000_0100, 0, 0};
        tbl[11] = '{32'h0000_0100, 32'h14A5_FFFE, 2'b10, 1'b1, 1'b1, 32'h0,        0, 0};
        tbl[12] = '{32'h0297_FFF8, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'h0000_0202, 0, 0};
        tbl[13] = '{32'h0000_0200, 32'h0000_0008, 2'b11, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, 0};
        tbl[14] = '{32'hFFFF_FFFC, 32'h2000_0004, 2'b00, 1'b0, 1'b0, 32'h0,        0, 0};
        tbl[15] = '{32'h0000_0000, 32'h0C00_0040, 2'b01, 1'b0, 1'b0, 32'h0,        0, 0};
        tbl[16] = '{32'h0000_0100, 32'h2000_0005, 2'b00, 1'b0, 1'b0, 32'h0,        1, 0};

        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        benign();
        tick();
        tick();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_before_edge", {31'h0, imem_req}, 32'h0);
        tick();
        chk("rel_req_after_edge", {31'h0, imem_req}, 32'h1);

        for (int i = 0; i < 17; i++) begin
            do_fetch(tbl[i]);
        end
        wait_req();
        chk("final_addr", imem_addr, 32'h0000_0104);

        // Reset in the middle of a handshake, with a stale ack held across release.
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        tick();
        chk("mid_valid", {31'h0, instr_valid}, 32'h1);
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        jmp         = 2'b11;
        jr_target   = 32'h0000_0500;
        tick();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
        instr_ready = 1'b0;
        benign();
        imem_rdata  = 32'h3333_4444;
        rst_n       = 1'b1;
        tick();
        chk("stale_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("stale_ack_req", {31'h0, imem_req}, 32'h1);
        tick();
        chk("post_rst_valid", {31'h0, instr_valid}, 32'h1);
        chk("post_rst_instr", instr, 32'h3333_4444);
        chk("post_rst_pc", pc, 32'h0);
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_req();
        chk("post_rst_next", imem_addr, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
